// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, access owner,
// timeout limits and a state-to-owner helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        F_ACC = 2'd1,
        M_ACC = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_M = 1'b1
    } arb_owner_e;

    localparam int unsigned TIMEOUT_MIN = 2;
    localparam int unsigned TIMEOUT_MAX = 255;

    function automatic arb_owner_e state_owner(input arb_state_e state);
        return (state == M_ACC) ? OWN_M : OWN_F;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating 8-bit wait counter for one memory access; expire marks the cycle in
// which the access has waited TIMEOUT_CYC cycles.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    output logic       expire_o
);

    // r_cnt holds completed wait cycles, so the current wait cycle is r_cnt + 1.
    localparam logic [7:0] EXPIRE_AT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
        end else if (clr_i) begin
            r_cnt <= 8'd0;
        end else if (en_i && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expire_o = (r_cnt >= EXPIRE_AT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and memory-stage accesses onto one single-port memory with a
// bounded-latency handshake; the data port has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    output logic              f_err_o,
    input  logic              m_req_i,
    input  logic              m_we_i,
    input  logic [ADDR_W-1:0] m_addr_i,
    input  logic [DATA_W-1:0] m_wdata_i,
    output logic              m_gnt_o,
    output logic              m_rvalid_o,
    output logic [DATA_W-1:0] m_rdata_o,
    output logic              m_err_o,
    output logic              f_stall_o,
    output logic              m_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    // Out-of-range timeouts are clamped rather than left to wrap the 8-bit counter.
    localparam int unsigned TIMEOUT_EFF =
        (TIMEOUT_CYC < TIMEOUT_MIN) ? TIMEOUT_MIN :
        (TIMEOUT_CYC > TIMEOUT_MAX) ? TIMEOUT_MAX : TIMEOUT_CYC;

    arb_state_e        r_state;
    arb_state_e        w_state_next;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_f_rvalid;
    logic [DATA_W-1:0] r_f_rdata;
    logic              r_f_err;
    logic              r_m_rvalid;
    logic [DATA_W-1:0] r_m_rdata;
    logic              r_m_err;

    logic              w_busy;
    logic              w_idle_open;
    logic              w_m_take;
    logic              w_f_take;
    logic              w_expire;
    logic              w_done;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic [DATA_W-1:0] w_cpl_rdata;
    logic              w_cpl_err;

    assign w_busy      = (r_state != IDLE);
    // The rvalid cycle is already in IDLE, but the requester still holds req there.
    assign w_idle_open = (r_state == IDLE) && !(r_f_rvalid || r_m_rvalid);
    assign w_m_take    = w_idle_open && m_req_i;
    assign w_f_take    = w_idle_open && !m_req_i && f_req_i;
    assign w_done      = w_busy && (mem_ack_i || w_expire);

    mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_EFF)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_tmr_clr),
        .en_i     (w_tmr_en),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_m_take) begin
                    w_state_next = M_ACC;
                end else if (w_f_take) begin
                    w_state_next = F_ACC;
                end
            end
            F_ACC, M_ACC: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        f_gnt_o   = w_f_take;
        m_gnt_o   = w_m_take;
        mem_req_o = w_busy;
        w_tmr_clr = w_m_take || w_f_take;
        w_tmr_en  = w_busy;
    end

    // Ack wins over a simultaneous timeout; writes always return zero data.
    assign w_cpl_rdata = (mem_ack_i && !r_we) ? mem_rdata_i : '0;
    assign w_cpl_err   = !mem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_f_rvalid <= 1'b0;
            r_f_rdata  <= '0;
            r_f_err    <= 1'b0;
            r_m_rvalid <= 1'b0;
            r_m_rdata  <= '0;
            r_m_err    <= 1'b0;
        end else begin
            r_f_rvalid <= 1'b0;
            r_m_rvalid <= 1'b0;
            if (w_m_take) begin
                r_we    <= m_we_i;
                r_addr  <= m_addr_i;
                r_wdata <= m_wdata_i;
            end else if (w_f_take) begin
                r_we    <= 1'b0;
                r_addr  <= f_addr_i;
                r_wdata <= '0;
            end
            if (w_done) begin
                if (state_owner(r_state) == OWN_M) begin
                    r_m_rvalid <= 1'b1;
                    r_m_rdata  <= w_cpl_rdata;
                    r_m_err    <= w_cpl_err;
                end else begin
                    r_f_rvalid <= 1'b1;
                    r_f_rdata  <= w_cpl_rdata;
                    r_f_err    <= w_cpl_err;
                end
            end
        end
    end

    assign f_rvalid_o  = r_f_rvalid;
    assign f_rdata_o   = r_f_rdata;
    assign f_err_o     = r_f_err;
    assign m_rvalid_o  = r_m_rvalid;
    assign m_rdata_o   = r_m_rdata;
    assign m_err_o     = r_m_err;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign f_stall_o   = f_req_i && !r_f_rvalid;
    assign m_stall_o   = m_req_i && !r_m_rvalid;

endmodule
